// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing source (pixel divider, h/v counters, syncs, frame pulse/count)
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 4 ? $clog2(CLK_DIV) : 2;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  localparam logic [9:0] HS_ON  = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_DISP + V_FP + V_SYNC);
  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_fs;
  logic [7:0]    r_fc;
  logic          w_tick;
  logic          w_h_end;
  logic          w_v_end;
  assign w_tick  = (r_div == DIV_MAX) & ~rst;
  assign w_h_end = r_h == H_MAX;
  assign w_v_end = r_v == V_MAX;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_fs  <= 1'b0;
      r_fc  <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      r_fs  <= w_tick & w_h_end & w_v_end;
      if (w_tick) begin
        r_h <= w_h_end ? '0 : r_h + 1'b1;
        if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
        if (w_h_end & w_v_end) r_fc <= r_fc + 1'b1;
      end
    end
  end
  assign h_cnt       = r_h;
  assign v_cnt       = r_v;
  assign pix_tick    = w_tick;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fc;
  assign valid       = ~rst & (r_h < H_VIS) & (r_v < V_VIS);
  assign hsync       = (~rst & (r_h >= HS_ON) & (r_h < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (~rst & (r_v >= VS_ON) & (r_v < VS_OFF)) ? SYNC_POL : ~SYNC_POL;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized reset stimulus, tick-count reference model, queued scoreboard
module tb_vga_sync_gen;
  localparam int CD = 3;
  localparam int HD = 5, HF = 1, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  typedef struct {
    int h, v, vl, hs, vs, tk, fs, fc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] h_cnt, v_cnt;
  logic valid, hsync, vsync, pix_tick, frame_start;
  logic [7:0] frame_cnt;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m = 0;
  bit done = 1'b0;
  vga_sync_gen #(
    .CLK_DIV(CD), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .hsync(hsync), .vsync(vsync), .pix_tick(pix_tick),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // Reference: everything follows from m, the count of non-reset edges since the last reset edge.
  function automatic exp_t model(input int mm, input bit r);
    exp_t e;
    int n;
    n = mm / CD;
    e.h  = n % HT;
    e.v  = (n / HT) % VT;
    e.vl = (!r && e.h < HD && e.v < VD) ? 1 : 0;
    e.hs = (!r && e.h >= HD + HF && e.h < HD + HF + HS) ? 0 : 1;
    e.vs = (!r && e.v >= VD + VF && e.v < VD + VF + VS) ? 0 : 1;
    e.tk = (!r && mm % CD == CD - 1) ? 1 : 0;
    e.fs = (mm > 0 && mm % CD == 0 && n % FT == 0) ? 1 : 0;
    e.fc = (n / FT) % 256;
    return e;
  endfunction
  task automatic step(input bit r);
    rst = r;
    m = r ? 0 : m + 1;
    q.push_back(model(m, r));
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 257 * FT * CD + 40; i++) step(1'b0);
    for (int s = 0; s < 25; s++) begin
      int len, rl;
      len = $urandom_range(1, 2 * FT * CD);
      rl = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) step(1'b0);
      for (int i = 0; i < rl; i++) step(1'b1);
    end
    for (int i = 0; i < FT * CD + 10; i++) step(1'b0);
    done = 1'b1;
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (!done) chk("queue_underflow", 0, 1);
      end else begin
        e = q.pop_front();
        chk("h_cnt", int'(h_cnt), e.h);
        chk("v_cnt", int'(v_cnt), e.v);
        chk("valid", int'(valid), e.vl);
        chk("hsync", int'(hsync), e.hs);
        chk("vsync", int'(vsync), e.vs);
        chk("pix_tick", int'(pix_tick), e.tk);
        chk("frame_start", int'(frame_start), e.fs);
        chk("frame_cnt", int'(frame_cnt), e.fc);
      end
    end
  end
endmodule
